// File: rtl/regfile_read_sequencer.sv
// regfile_read_sequencer
//   The register file has one asynchronous read port. This block shares it
//   between the two source operands of one instruction. It reads rs1 and then
//   rs2 on successive cycles and returns both operands together.
//   Captured operands see a write at the capture edge, which bypasses the
//   register file. Operands waiting to be returned are kept coherent with later
//   writes by snooping the write port.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   req_valid/req_ready      operand request handshake (decode side)
//   req_rs1, req_rs2         source register addresses
//   rsp_valid/rsp_ready      operand response handshake (execute side)
//   rsp_rs1_data/_rs2_data   registered operand values
//   rf_location_read         register file read address
//   rf_out                   register file asynchronous read data
//   wr_en/wr_addr/wr_data    snooped register file write port
module regfile_read_sequencer #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rs1_data,
  output logic [WIDTH-1:0] rsp_rs2_data,
  output logic [4:0]       rf_location_read,
  input  logic [WIDTH-1:0] rf_out,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ1 = 2'd1,
    READ2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic [WIDTH-1:0] d2_q, d2_d;
  logic             rsp_valid_q;

  // Address 0 reads as zero when ZERO_REG is set.
  function automatic logic is_zero_reg(input logic [4:0] addr);
    return (ZERO_REG != 1'b0) && (addr == 5'd0);
  endfunction

  // Resolves the value captured for addr.
  // Priority: hardwired zero, then a write at this edge, then register file data.
  function automatic logic [WIDTH-1:0] resolve_operand(
    input logic [4:0]       addr,
    input logic [WIDTH-1:0] rd_data,
    input logic             we,
    input logic [4:0]       waddr,
    input logic [WIDTH-1:0] wdata
  );
    if (is_zero_reg(addr)) begin
      return '0;
    end else if (we && (waddr == addr)) begin
      return wdata;
    end else begin
      return rd_data;
    end
  endfunction

  // A write updates a held operand when it targets the same register.
  // A write to the hardwired zero register never updates a held operand.
  function automatic logic snoop_hit(
    input logic [4:0] addr,
    input logic       we,
    input logic [4:0] waddr
  );
    return we && (waddr == addr) && !is_zero_reg(addr);
  endfunction

  // Next-state logic, operand capture and coherence snooping.
  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          state_d = READ1;
        end else begin
          state_d = IDLE;
        end
      end
      READ1: begin
        d1_d = resolve_operand(rs1_q, rf_out, wr_en, wr_addr, wr_data);
        // When both addresses match, one read serves both operands.
        if (rs1_q == rs2_q) begin
          d2_d    = resolve_operand(rs1_q, rf_out, wr_en, wr_addr, wr_data);
          state_d = DONE;
        end else begin
          state_d = READ2;
        end
      end
      READ2: begin
        d2_d = resolve_operand(rs2_q, rf_out, wr_en, wr_addr, wr_data);
        if (snoop_hit(rs1_q, wr_en, wr_addr)) begin
          d1_d = wr_data;
        end else begin
          d1_d = d1_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (snoop_hit(rs1_q, wr_en, wr_addr)) begin
          d1_d = wr_data;
        end else begin
          d1_d = d1_q;
        end
        if (snoop_hit(rs2_q, wr_en, wr_addr)) begin
          d2_d = wr_data;
        end else begin
          d2_d = d2_q;
        end
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched addresses, operand registers and the response valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      d1_q        <= '0;
      d2_q        <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      rsp_valid_q <= (state_d == DONE);
    end
  end

  // The read address must be valid in the same cycle because the port reads
  // asynchronously. The address is parked at 0 when no read is in progress.
  always_comb begin
    case (state_q)
      READ1:   rf_location_read = rs1_q;
      READ2:   rf_location_read = rs2_q;
      default: rf_location_read = 5'd0;
    endcase
  end

  assign req_ready    = (state_q == IDLE) && !reset;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rs1_data = d1_q;
  assign rsp_rs2_data = d2_q;

endmodule

// File: tb/tb_regfile_read_sequencer.sv
module tb_regfile_read_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;
  logic [4:0]  rf_location_read;
  logic [31:0] rf_out;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] rf [32];

  int checks_q;
  int errors_q;

  regfile_read_sequencer #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_rs1          (req_rs1),
    .req_rs2          (req_rs2),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rs1_data     (rsp_rs1_data),
    .rsp_rs2_data     (rsp_rs2_data),
    .rf_location_read (rf_location_read),
    .rf_out           (rf_out),
    .wr_en            (wr_en),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple register file: x0 is stored like any other register.
  // The sequencer must hide the stored x0 value.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign rf_out = rf[rf_location_read];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      errors_q++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    checks_q  = 0;
    errors_q  = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
    rsp_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'd0;

    tick();
    tick();
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rs1_data", rsp_rs1_data, 32'd0);
    check_eq("rst_rs2_data", rsp_rs2_data, 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rf_addr", 32'(rf_location_read), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("idle_req_ready", 32'(req_ready), 32'd1);

    // Preload the register file, including a stored write to x0.
    write_reg(5'd3, 32'h11);
    write_reg(5'd5, 32'h22);
    write_reg(5'd7, 32'hABCD);
    write_reg(5'd4, 32'h5);
    write_reg(5'd0, 32'hFF);

    // Distinct registers: READ1 -> READ2 -> DONE.
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd5;
    tick();
    req_valid = 1'b0;
    check_eq("t1_read1_addr", 32'(rf_location_read), 32'd3);
    check_eq("t1_read1_ready", 32'(req_ready), 32'd0);
    check_eq("t1_read1_valid", 32'(rsp_valid), 32'd0);
    tick();
    check_eq("t1_read2_addr", 32'(rf_location_read), 32'd5);
    check_eq("t1_read2_valid", 32'(rsp_valid), 32'd0);
    tick();
    check_eq("t1_done_valid", 32'(rsp_valid), 32'd1);
    check_eq("t1_rs1", rsp_rs1_data, 32'h11);
    check_eq("t1_rs2", rsp_rs2_data, 32'h22);
    check_eq("t1_done_addr", 32'(rf_location_read), 32'd0);
    check_eq("t1_done_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("t1_idle_valid", 32'(rsp_valid), 32'd0);
    check_eq("t1_idle_ready", 32'(req_ready), 32'd1);

    // Same register: READ1 goes straight to DONE.
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd7;
    tick();
    req_valid = 1'b0;
    check_eq("t2_read1_addr", 32'(rf_location_read), 32'd7);
    tick();
    check_eq("t2_done_valid", 32'(rsp_valid), 32'd1);
    check_eq("t2_rs1", rsp_rs1_data, 32'hABCD);
    check_eq("t2_rs2", rsp_rs2_data, 32'hABCD);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // The x0 operand reads as zero even though the register file stores 0xFF there.
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd4;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check_eq("t3_done_valid", 32'(rsp_valid), 32'd1);
    check_eq("t3_rs1_x0", rsp_rs1_data, 32'h0);
    check_eq("t3_rs2", rsp_rs2_data, 32'h5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // A write at the READ2 capture edge bypasses the register file.
    // A write while in DONE updates the held operand.
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd5;
    tick();
    req_valid = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h99;
    tick();
    wr_en = 1'b0;
    check_eq("t4_bypass_rs2", rsp_rs2_data, 32'h99);
    check_eq("t4_bypass_rs1", rsp_rs1_data, 32'h11);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    check_eq("t4_snoop_rs1", rsp_rs1_data, 32'h77);
    check_eq("t4_snoop_valid", 32'(rsp_valid), 32'd1);

    // Backpressure: the response holds and a pending request waits.
    req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("t5_hold_rs1", rsp_rs1_data, 32'h77);
      check_eq("t5_hold_rs2", rsp_rs2_data, 32'h99);
      check_eq("t5_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("t5_idle_valid", 32'(rsp_valid), 32'd0);
    check_eq("t5_idle_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check_eq("t5_b2b_read1", 32'(rf_location_read), 32'd1);
    tick();
    check_eq("t5_b2b_read2", 32'(rf_location_read), 32'd2);

    // Reset during READ2 abandons the request.
    reset = 1'b1;
    tick();
    check_eq("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("t6_rst_rs1", rsp_rs1_data, 32'd0);
    check_eq("t6_rst_rs2", rsp_rs2_data, 32'd0);
    check_eq("t6_rst_ready", 32'(req_ready), 32'd0);
    check_eq("t6_rst_addr", 32'(rf_location_read), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check_eq("t6_idle_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
    $finish;
  end

endmodule
